pagerank_iter_ctrl: RTL
=======================

# pagerank_iter_ctrl

Iteration controller for the PageRank node-value engine. Latches a graph configuration on `start` and initialises the engine. It then steps the engine one iteration at a time and, after each iteration, scans all N node values serially against the previous iteration's snapshot. It stops when the largest per-node change is within tolerance or an iteration limit is hit. It sits between the host/config side and the engine, and owns the engine's init and step-enable controls.

## Interface
- `N`, 4: number of graph nodes.
- `WIDTH`, 16: node value width, unsigned fraction in [0, (2^WIDTH-1)/2^WIDTH].
- `ITER_W`, 8: iteration counter width.
- `INIT_VAL`, 2^WIDTH/N (16'h4000 for N=4): engine value after init; also the initial snapshot value.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE and clears every register.
- `start` in 1: run request; sampled only in IDLE.
- `cfg_adjacency` in N*N: adjacency matrix, row-major, bit j*N+k = edge k→j.
- `cfg_weights` in N*WIDTH: per-node out-weights, node r at [r*WIDTH+:WIDTH].
- `tol` in WIDTH: convergence tolerance, unsigned.
- `max_iter` in ITER_W: iteration limit; 0 = no limit.
- `eng_vals` in N*WIDTH: engine node values, node r at [r*WIDTH+:WIDTH].
- `eng_adjacency` out N*N: latched adjacency to engine.
- `eng_weights` out N*WIDTH: latched weights to engine.
- `eng_init` out 1: one-cycle pulse; engine loads INIT_VAL into all nodes.
- `eng_step` out 1: one-cycle pulse; engine performs one iteration and updates `eng_vals` on that edge.
- `busy` out 1: high from INIT through DONE inclusive.
- `done` out 1: one-cycle pulse at end of run.
- `converged` out 1: run ended by tolerance (valid from `done`, held until next accepted `start`).
- `iter_count` out ITER_W: iterations performed (held until next accepted `start`).
- `max_delta` out WIDTH: largest |change| in the last completed scan (held like `iter_count`).

## Operation
- States: IDLE, INIT, STEP, CHECK, DONE.
- IDLE: `start`=1 → INIT. On the same edge, latch `cfg_adjacency`/`cfg_weights`, and clear `iter_count`, `converged`, `max_delta` and the scan max.
- INIT (1 cycle): `eng_init`=1; load all N snapshot registers with INIT_VAL → STEP.
- STEP (1 cycle): `eng_step`=1; `iter_count` += 1 (saturating at 2^ITER_W-1); clear scan max; scan index=0 → CHECK.
- CHECK (N cycles, node idx = 0..N-1):
  - d = |eng_vals[idx] − snap[idx]|, unsigned.
  - scan max = max(scan max, d).
  - snap[idx] ← eng_vals[idx].
- Last CHECK cycle: `max_delta` ← final scan max.
  - If final max ≤ `tol` → `converged`=1 → DONE.
  - Else if `max_iter`≠0 and `iter_count` == `max_iter` → `converged`=0 → DONE.
  - Else → STEP.
- DONE (1 cycle): `done`=1 → IDLE.
- `start` outside IDLE is ignored (not queued).
- `tol`/`max_iter` are sampled live in the last CHECK cycle; the host holds them stable while `busy`.
- Config outputs hold the latched values until the next accepted `start`.
- Reset mid-run: immediate IDLE; `eng_init`, `eng_step`, `busy`, `done` drop asynchronously; no `done` is issued.

## Timing
- Reset values: every output 0, except that config outputs and snapshots are also 0.
- `start` high in cycle 0 → INIT cycle 1, STEP cycle 2, CHECK cycles 3..N+2.
- Each iteration costs 1+N cycles.
- A run of I iterations ends with `done` in cycle 2+I(1+N), e.g. cycle 7 for N=4, I=1.
- Earliest re-accepted `start`: the cycle after `done`.

## Structure
- Package `pagerank_pkg`: state enum, default WIDTH/N/ITER_W, INIT_VAL function of N/WIDTH, adjacency/weight slicing helpers.
- Sub-module `pagerank_delta_unit`: abs-diff plus running max, with a clear input.

## Test plan
- Reset asserted mid-idle and at power-up → all outputs 0, state IDLE, `busy`=0.
- Engine model holds 16'h4000 constant, `tol`=0, N=4 → `done` at cycle 7, `converged`=1, `iter_count`=1, `max_delta`=0.
- Engine adds 2 to every node per step, `tol`=1, `max_iter`=5 → `done` at cycle 27, `converged`=0, `iter_count`=5, `max_delta`=2.
- Boundary: one node changes by exactly `tol`=16'h0010 → converged on that iteration; change of 16'h0011 → not converged.
- Second `start` pulsed during CHECK and during DONE → ignored, a single `done`; config latched from the first `start` only.
- `reset` pulsed during the 2nd CHECK → `eng_step`/`busy` low at once, no `done`; a new `start` then restarts from INIT with `iter_count` counting from 1.

Source files
------------

// File: rtl/pagerank_pkg.sv
// Shared types, default sizes and slicing helpers for the PageRank iteration
// controller and its delta unit.
package pagerank_pkg;

    localparam int unsigned DEF_N      = 4;
    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_ITER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_STEP  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Uniform starting value: one share of the unit fraction per node.
    function automatic logic [31:0] init_val(input int unsigned n, input int unsigned width);
        return (32'd1 << width) / n;
    endfunction

    function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

    // Bit position of edge src->dst in a row-major adjacency vector.
    function automatic int unsigned adj_bit(input int unsigned dst, input int unsigned src,
                                            input int unsigned n);
        return dst * n + src;
    endfunction

endpackage

// File: rtl/pagerank_delta_unit.sv
// Absolute difference of two node values folded into a running maximum.
// next_max is the maximum including the current sample; it becomes run_max on the edge.
module pagerank_delta_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] cur_val,
    input  logic [WIDTH-1:0] prev_val,
    output logic [WIDTH-1:0] next_max
);

    logic [WIDTH-1:0] run_max_r;
    logic [WIDTH-1:0] delta_s;
    logic [WIDTH-1:0] next_max_s;

    // Unsigned absolute difference.
    always_comb begin
        delta_s = '0;
        if (cur_val >= prev_val) begin
            delta_s = cur_val - prev_val;
        end else begin
            delta_s = prev_val - cur_val;
        end
    end

    // Running-max update selection.
    always_comb begin
        next_max_s = run_max_r;
        if (clear) begin
            next_max_s = '0;
        end else if (enable && (delta_s > run_max_r)) begin
            next_max_s = delta_s;
        end else begin
            next_max_s = run_max_r;
        end
    end

    // Running-max register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_max_r <= '0;
        end else begin
            run_max_r <= next_max_s;
        end
    end

    assign next_max = next_max_s;

endmodule

// File: rtl/pagerank_iter_ctrl.sv
// Iteration controller: initialises the engine, steps it, and serially scans
// node values against the previous snapshot until convergence or iteration limit.
module pagerank_iter_ctrl
    import pagerank_pkg::*;
#(
    parameter int unsigned      N        = DEF_N,
    parameter int unsigned      WIDTH    = DEF_WIDTH,
    parameter int unsigned      ITER_W   = DEF_ITER_W,
    parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(init_val(N, WIDTH))
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N*N-1:0]       cfg_adjacency,
    input  logic [N*WIDTH-1:0]   cfg_weights,
    input  logic [WIDTH-1:0]     tol,
    input  logic [ITER_W-1:0]    max_iter,
    input  logic [N*WIDTH-1:0]   eng_vals,
    output logic [N*N-1:0]       eng_adjacency,
    output logic [N*WIDTH-1:0]   eng_weights,
    output logic                 eng_init,
    output logic                 eng_step,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [ITER_W-1:0]    iter_count,
    output logic [WIDTH-1:0]     max_delta
);

    localparam int unsigned       IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam logic [ITER_W-1:0] ITER_MAX = {ITER_W{1'b1}};

    state_e             state_r;
    state_e             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   snap_r [N];
    logic [WIDTH-1:0]   eng_val_a_s [N];
    logic [N*N-1:0]     adj_r;
    logic [N*WIDTH-1:0] wts_r;
    logic [ITER_W-1:0]  iter_count_r;
    logic               converged_r;
    logic [WIDTH-1:0]   max_delta_r;
    logic               eng_init_r;
    logic               eng_step_r;
    logic               busy_r;
    logic               done_r;
    logic               init_next_s;
    logic               step_next_s;
    logic               busy_next_s;
    logic               done_next_s;
    logic               start_acc_s;
    logic               last_check_s;
    logic               within_tol_s;
    logic               limit_hit_s;
    logic [WIDTH-1:0]   cur_val_s;
    logic [WIDTH-1:0]   prev_val_s;
    logic [WIDTH-1:0]   max_next_s;

    // Unpack engine values into per-node words.
    always_comb begin
        for (int unsigned r = 0; r < N; r++) begin
            eng_val_a_s[r] = eng_vals[word_lsb(r, WIDTH) +: WIDTH];
        end
    end

    assign start_acc_s  = (state_r == ST_IDLE) && start;
    assign last_check_s = (state_r == ST_CHECK) && (idx_r == LAST_IDX);
    assign cur_val_s    = eng_val_a_s[idx_r];
    assign prev_val_s   = snap_r[idx_r];
    assign within_tol_s = (max_next_s <= tol);
    assign limit_hit_s  = (max_iter != {ITER_W{1'b0}}) && (iter_count_r == max_iter);

    pagerank_delta_unit #(
        .WIDTH (WIDTH)
    ) u_delta (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_acc_s || (state_r == ST_STEP)),
        .enable   (state_r == ST_CHECK),
        .cur_val  (cur_val_s),
        .prev_val (prev_val_s),
        .next_max (max_next_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_INIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_INIT: state_next_s = ST_STEP;
            ST_STEP: state_next_s = ST_CHECK;
            ST_CHECK: begin
                if (!last_check_s) begin
                    state_next_s = ST_CHECK;
                end else if (within_tol_s || limit_hit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_STEP;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the upcoming state so they register in phase with it.
    always_comb begin
        init_next_s = 1'b0;
        step_next_s = 1'b0;
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE:  busy_next_s = 1'b0;
            ST_INIT: begin
                init_next_s = 1'b1;
                busy_next_s = 1'b1;
            end
            ST_STEP: begin
                step_next_s = 1'b1;
                busy_next_s = 1'b1;
            end
            ST_CHECK: busy_next_s = 1'b1;
            ST_DONE: begin
                done_next_s = 1'b1;
                busy_next_s = 1'b1;
            end
            default: busy_next_s = 1'b0;
        endcase
    end

    // Control output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_init_r <= 1'b0;
            eng_step_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            eng_init_r <= init_next_s;
            eng_step_r <= step_next_s;
            busy_r     <= busy_next_s;
            done_r     <= done_next_s;
        end
    end

    // Configuration latched only on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adj_r <= '0;
            wts_r <= '0;
        end else if (start_acc_s) begin
            adj_r <= cfg_adjacency;
            wts_r <= cfg_weights;
        end
    end

    // Iteration counter, scan index, snapshots and run results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r        <= '0;
            iter_count_r <= '0;
            converged_r  <= 1'b0;
            max_delta_r  <= '0;
            for (int unsigned r = 0; r < N; r++) begin
                snap_r[r] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        iter_count_r <= '0;
                        converged_r  <= 1'b0;
                        max_delta_r  <= '0;
                    end
                end
                ST_INIT: begin
                    for (int unsigned r = 0; r < N; r++) begin
                        snap_r[r] <= INIT_VAL;
                    end
                end
                ST_STEP: begin
                    if (iter_count_r != ITER_MAX) begin
                        iter_count_r <= iter_count_r + {{(ITER_W-1){1'b0}}, 1'b1};
                    end
                    idx_r <= '0;
                end
                ST_CHECK: begin
                    snap_r[idx_r] <= cur_val_s;
                    idx_r         <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    if (last_check_s) begin
                        max_delta_r <= max_next_s;
                        converged_r <= within_tol_s;
                    end
                end
                default: idx_r <= idx_r;
            endcase
        end
    end

    assign eng_adjacency = adj_r;
    assign eng_weights   = wts_r;
    assign eng_init      = eng_init_r;
    assign eng_step      = eng_step_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign converged     = converged_r;
    assign iter_count    = iter_count_r;
    assign max_delta     = max_delta_r;

endmodule
